usbcmd: RTL and testbench

Command decoder that sits directly downstream of the FT2232H FIFO interface stage and turns its received byte stream into memory-bus transactions. It collects fixed-length command frames (ping, write, read), issues a single read or write on the memio bus with a request/ack handshake, and returns a one-byte response to the transmit side of the USB interface. Malformed opcodes and stalled frames are dropped and flagged on `error`.

---
 rtl/usbcmd.sv | 166 ++++++++++++++++
 tb/tb_usbcmd.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbcmd.sv
// usbcmd: byte-stream command decoder. Collects ping/write/read frames from
// the USB receive side, runs one memio request/ack transaction and returns a
// single response byte on the transmit side.
module usbcmd #(
  parameter int ADDRWIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ack,
  output logic                 error
);

  localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  localparam logic [7:0] OP_PING  = 8'h50;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_PING = 8'h55;
  localparam logic [7:0] RSP_WACK = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    ADDRHI,
    ADDRLO,
    WDATA,
    MEMWR,
    MEMRD,
    TXRESP
  } state_t;

  state_t                r_state;
  state_t                w_state_n;
  logic [CW-1:0]         r_cnt;
  logic [7:0]            r_addr_hi;
  logic                  r_is_read;
  logic [7:0]            r_tx_data;
  logic [ADDRWIDTH-1:0]  r_mem_addr;
  logic [7:0]            r_mem_wdata;
  logic                  r_error;
  logic                  w_accept;
  logic                  w_counting;
  logic                  w_timeout;
  logic                  w_error_n;
  logic [15:0]           w_addr16;

  assign w_accept   = rx_valid & rx_ready;
  assign w_counting = (r_state == ADDRHI) || (r_state == ADDRLO) || (r_state == WDATA);
  // A byte accepted on the expiry edge takes priority over the timeout.
  assign w_timeout  = w_counting & ~rx_valid & (r_cnt == TO_VAL);
  assign w_addr16   = {r_addr_hi, rx_data};

  assign tx_data    = r_tx_data;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign error      = r_error;

  // State register; reset abandons any partial frame or pending request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_n;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    w_state_n = r_state;
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    tx_valid  = 1'b0;
    w_error_n = 1'b0;
    case (r_state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_data == OP_PING)                           w_state_n = TXRESP;
          else if (rx_data == OP_WRITE || rx_data == OP_READ) w_state_n = ADDRHI;
          else                                              w_error_n = 1'b1;
        end
      end
      ADDRHI: begin
        rx_ready = 1'b1;
        if (rx_valid)       w_state_n = ADDRLO;
        else if (w_timeout) begin
          w_state_n = IDLE;
          w_error_n = 1'b1;
        end
      end
      ADDRLO: begin
        rx_ready = 1'b1;
        if (rx_valid)       w_state_n = r_is_read ? MEMRD : WDATA;
        else if (w_timeout) begin
          w_state_n = IDLE;
          w_error_n = 1'b1;
        end
      end
      WDATA: begin
        rx_ready = 1'b1;
        if (rx_valid)       w_state_n = MEMWR;
        else if (w_timeout) begin
          w_state_n = IDLE;
          w_error_n = 1'b1;
        end
      end
      MEMWR: begin
        mem_we = 1'b1;
        if (mem_ack) w_state_n = TXRESP;
      end
      MEMRD: begin
        mem_re = 1'b1;
        if (mem_ack) w_state_n = TXRESP;
      end
      TXRESP: begin
        tx_valid = 1'b1;
        if (tx_ready) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Frame fields, response byte, inter-byte timeout counter and error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_addr_hi   <= '0;
      r_is_read   <= 1'b0;
      r_tx_data   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_error     <= 1'b0;
    end else begin
      r_error <= w_error_n;

      if (w_counting && !w_accept && !w_timeout) r_cnt <= r_cnt + 1'b1;
      else                                       r_cnt <= '0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (rx_data == OP_PING) r_tx_data <= RSP_PING;
            r_is_read <= (rx_data == OP_READ);
          end
        end
        ADDRHI: if (w_accept) r_addr_hi   <= rx_data;
        ADDRLO: if (w_accept) r_mem_addr  <= ADDRWIDTH'(w_addr16);
        WDATA:  if (w_accept) r_mem_wdata <= rx_data;
        MEMWR:  if (mem_ack)  r_tx_data   <= RSP_WACK;
        MEMRD:  if (mem_ack)  r_tx_data   <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usbcmd.sv
// Testbench for usbcmd: table of command frames checked through a response
// scoreboard, plus hand sequences for timeout, timeout boundary and reset.
module tb_usbcmd;

  localparam int TO = 4;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic        rx_valid  = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready  = 1'b1;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'hEE;
  logic        mem_ack   = 1'b0;
  logic        error;

  always #5 clock = ~clock;

  usbcmd #(.ADDRWIDTH(16), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .error     (error)
  );

  int          ntests = 0;
  int          nfail  = 0;
  logic [7:0]  exp_q[$];
  int          err_cnt = 0, we_cyc = 0, re_cyc = 0, tv_cyc = 0;
  logic [15:0] cap_addr, cap_raddr;
  logic [7:0]  cap_wdata;
  int          ack_dly = 0;
  int          tx_hold = 0;
  bit          resp_en = 1'b1;
  logic [7:0]  mem_img [0:255];

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
    int          ack;
    int          hold;
    bit          has_resp;
    logic [7:0]  resp;
    int          errs;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, stability and one-state-output checks, mid-cycle.
  logic       prev_tv = 1'b0, prev_xfer = 1'b0, prev_err = 1'b0;
  logic [7:0] prev_td = 8'h00;
  always @(negedge clock) begin
    if (reset_n) begin
      check("one_state_output",
            int'(rx_ready) + int'(mem_we) + int'(mem_re) + int'(tx_valid), 1);
      if (error) begin
        err_cnt++;
        check("error_one_cycle", prev_err, 0);
      end
      if (mem_we) begin
        if (we_cyc > 0) begin
          check("mem_addr_stable_wr", mem_addr, cap_addr);
          check("mem_wdata_stable", mem_wdata, cap_wdata);
        end else begin
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
        end
        we_cyc++;
      end
      if (mem_re) begin
        if (re_cyc > 0) check("mem_addr_stable_rd", mem_addr, cap_raddr);
        else            cap_raddr = mem_addr;
        re_cyc++;
      end
      if (tx_valid) begin
        tv_cyc++;
        if (prev_tv && !prev_xfer) check("tx_data_stable", tx_data, prev_td);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL tx_unexpected: got 0x%0h, no response was due", tx_data);
        end else begin
          check("tx_response", tx_data, exp_q.pop_front());
        end
      end
      prev_tv   = tx_valid;
      prev_xfer = tx_valid && tx_ready;
      prev_td   = tx_data;
      prev_err  = error;
    end else begin
      prev_tv   = 1'b0;
      prev_xfer = 1'b0;
      prev_err  = 1'b0;
    end
  end

  // Memory responder: acks after ack_dly extra cycles, serves reads from mem_img.
  int rsp_cnt = 0;
  always begin
    @(posedge clock); #1;
    if (resp_en) begin
      mem_ack = 1'b0;
      if (mem_we || mem_re) begin
        if (rsp_cnt >= ack_dly) begin
          mem_ack = 1'b1;
          rsp_cnt = 0;
          if (mem_re) mem_rdata = mem_img[mem_addr[7:0]];
          else        mem_img[mem_addr[7:0]] = mem_wdata;
        end else begin
          rsp_cnt++;
        end
      end else begin
        rsp_cnt   = 0;
        mem_rdata = 8'hEE;
      end
    end
  end

  // Transmit sink: holds tx_ready low for tx_hold cycles of each response.
  int hcnt = 0;
  always begin
    @(posedge clock); #1;
    if (!tx_valid) begin
      hcnt     = 0;
      tx_ready = (tx_hold == 0);
    end else if (hcnt < tx_hold) begin
      tx_ready = 1'b0;
      hcnt++;
    end else begin
      tx_ready = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      acc = rx_ready;
      @(posedge clock); #1;
      if (acc) break;
    end
    rx_valid = 1'b0;
    check("rx_accepted", acc, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && rx_ready && !tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
    check("frame_done", ok, 1);
  endtask

  task automatic clear_counts();
    err_cnt = 0;
    we_cyc  = 0;
    re_cyc  = 0;
    tv_cyc  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_img[i] = 8'(i) ^ 8'hC3;

    //                op     addr      data   ack hold resp resp   errs
    vecs[0]  = '{8'h50, 16'h0000, 8'h00, 0, 0, 1'b1, 8'h55, 0};
    vecs[1]  = '{8'h57, 16'h1234, 8'hAB, 2, 0, 1'b1, 8'h06, 0};
    vecs[2]  = '{8'h52, 16'h1234, 8'h00, 0, 0, 1'b1, 8'hAB, 0};
    vecs[3]  = '{8'h41, 16'h0000, 8'h00, 0, 0, 1'b0, 8'h00, 1};
    vecs[4]  = '{8'h50, 16'h0000, 8'h00, 0, 0, 1'b1, 8'h55, 0};
    vecs[5]  = '{8'h57, 16'h0010, 8'h5A, 0, 0, 1'b1, 8'h06, 0};
    vecs[6]  = '{8'h52, 16'h0010, 8'h00, 1, 4, 1'b1, 8'h5A, 0};
    vecs[7]  = '{8'h52, 16'h0077, 8'h00, 0, 0, 1'b1, 8'hB4, 0};
    vecs[8]  = '{8'h57, 16'h00FE, 8'hFF, 5, 2, 1'b1, 8'h06, 0};
    vecs[9]  = '{8'h52, 16'h00FE, 8'h00, 3, 0, 1'b1, 8'hFF, 0};
    vecs[10] = '{8'hFF, 16'h0000, 8'h00, 0, 0, 1'b0, 8'h00, 1};

    // reset state
    repeat (3) @(negedge clock);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_error", error, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle_cycles(2);

    // table-driven frames
    for (int i = 0; i < 11; i++) begin
      ack_dly = vecs[i].ack;
      tx_hold = vecs[i].hold;
      idle_cycles(1);
      clear_counts();
      if (vecs[i].has_resp) exp_q.push_back(vecs[i].resp);
      send_byte(vecs[i].op);
      if (vecs[i].op == 8'h57 || vecs[i].op == 8'h52) begin
        send_byte(vecs[i].addr[15:8]);
        send_byte(vecs[i].addr[7:0]);
        if (vecs[i].op == 8'h57) send_byte(vecs[i].data);
      end
      wait_done();
      check($sformatf("v%0d_errors", i), err_cnt, vecs[i].errs);
      if (vecs[i].op == 8'h57) begin
        check($sformatf("v%0d_we_cycles", i), we_cyc, vecs[i].ack + 1);
        check($sformatf("v%0d_wr_addr", i), cap_addr, vecs[i].addr);
        check($sformatf("v%0d_wr_data", i), cap_wdata, vecs[i].data);
      end
      if (vecs[i].op == 8'h52) begin
        check($sformatf("v%0d_re_cycles", i), re_cyc, vecs[i].ack + 1);
        check($sformatf("v%0d_rd_addr", i), cap_raddr, vecs[i].addr);
      end
      if (vecs[i].has_resp)
        check($sformatf("v%0d_tx_cycles", i), tv_cyc, vecs[i].hold + 1);
    end
    ack_dly = 0;
    tx_hold = 0;
    idle_cycles(1);

    // timeout: partial write frame abandoned after TO idle edges plus expiry edge
    clear_counts();
    send_byte(8'h57);
    send_byte(8'h12);
    idle_cycles(TO);
    check("to_no_error_early", err_cnt, 0);
    check("to_error_low_early", error, 0);
    idle_cycles(1);
    check("to_error_pulse", error, 1);
    exp_q.push_back(8'h55);
    send_byte(8'h50);
    wait_done();
    check("to_error_count", err_cnt, 1);
    check("to_no_mem_write", we_cyc, 0);

    // timeout boundary: bytes arriving exactly on the expiry edge are accepted
    clear_counts();
    send_byte(8'h57);
    send_byte(8'h12);
    idle_cycles(TO);
    send_byte(8'h34);
    idle_cycles(TO);
    send_byte(8'hCD);
    exp_q.push_back(8'h06);
    wait_done();
    check("tob_error_count", err_cnt, 0);
    check("tob_wr_addr", cap_addr, 16'h1234);
    check("tob_wr_data", cap_wdata, 8'hCD);

    // asynchronous reset while a read is pending
    resp_en = 1'b0;
    mem_ack = 1'b0;
    clear_counts();
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h10);
    @(negedge clock);
    check("rr_mem_re_pending", mem_re, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rr_mem_re_dropped", mem_re, 0);
    check("rr_tx_valid_low", tx_valid, 0);
    check("rr_mem_addr_cleared", mem_addr, 0);
    check("rr_rx_ready_idle", rx_ready, 1);
    idle_cycles(2);
    reset_n = 1'b1;
    mem_rdata = 8'h77;
    mem_ack   = 1'b1;
    idle_cycles(1);
    mem_ack   = 1'b0;
    @(negedge clock);
    check("rr_ack_ignored_tx", tx_valid, 0);
    check("rr_ack_ignored_re", mem_re, 0);
    check("rr_ack_ignored_idle", rx_ready, 1);
    @(posedge clock); #1;
    resp_en = 1'b1;
    idle_cycles(1);
    exp_q.push_back(8'h55);
    send_byte(8'h50);
    wait_done();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
